// File: rtl/vga_scanout_pkg.sv
// Shared widths, pixel payload type and framebuffer address helper for the VGA scan-out path.
package vga_scanout_pkg;

  localparam int unsigned SCALE_LOG2 = 2;
  localparam int unsigned FB_W       = 160;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned H_W        = 10;
  localparam int unsigned V_W        = 10;
  localparam int unsigned FB_X_W     = H_W - SCALE_LOG2;
  localparam int unsigned FB_Y_W     = V_W - SCALE_LOG2;
  localparam int unsigned RGB_W      = 3;
  localparam int unsigned DAC_W      = 10;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  // y*160 + x as shift-add: y*128 + y*32 + x.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [FB_Y_W-1:0] y,
                                                input logic [FB_X_W-1:0] x);
    return ADDR_W'({y, 7'b0}) + ADDR_W'({y, 5'b0}) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/vga_scanout_sync_counter.sv
// Pixel-enable divider, h/v raster counters, sync/visible decode and frame-start pulse.
module vga_scanout_sync_counter
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic           clock,
  input  logic           reset,
  output logic           pix_en,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           visible_c,
  output logic           hs_n_c,
  output logic           vs_n_c,
  output logic           frame_start
);

  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned HS_START = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned VS_START = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic h_last;
  logic v_last;

  assign h_last = (h == H_W'(H_TOTAL - 1));
  assign v_last = (v == V_W'(V_TOTAL - 1));

  // Counters step once per pixel period; frame_start follows the wrap to (0,0).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_en      <= 1'b0;
      h           <= '0;
      v           <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= pix_en && h_last && v_last;
      if (pix_en) begin
        if (h_last) begin
          h <= '0;
          v <= v_last ? '0 : v + V_W'(1);
        end else begin
          h <= h + H_W'(1);
        end
      end
    end
  end

  assign visible_c = (h < H_W'(H_VIS)) && (v < V_W'(V_VIS));
  assign hs_n_c    = !((h >= H_W'(HS_START)) && (h < H_W'(HS_END)));
  assign vs_n_c    = !((v >= V_W'(VS_START)) && (v < V_W'(VS_END)));

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer read side: 640x480@60 timing, 4x4 pixel scaling, VGA DAC output registers.
// Optional colour-bar generator enabled by defining VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic              clock,
  input  logic              reset,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [RGB_W-1:0]  rd_data,
  output logic              frame_start,
  output logic [DAC_W-1:0]  VGA_R,
  output logic [DAC_W-1:0]  VGA_G,
  output logic [DAC_W-1:0]  VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK,
  output logic              VGA_SYNC,
  output logic              VGA_CLK
);

  logic           pix_en;
  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           visible_c;
  logic           hs_n_c;
  logic           vs_n_c;

  vga_scanout_sync_counter #(
    .H_VIS (H_VIS),
    .H_FP  (H_FP),
    .H_SYNC(H_SYNC),
    .H_BP  (H_BP),
    .V_VIS (V_VIS),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP)
  ) u_sync (
    .clock      (clock),
    .reset      (reset),
    .pix_en     (pix_en),
    .h          (h),
    .v          (v),
    .visible_c  (visible_c),
    .hs_n_c     (hs_n_c),
    .vs_n_c     (vs_n_c),
    .frame_start(frame_start)
  );

  assign rd_addr = visible_c ? fb_addr(v[V_W-1:SCALE_LOG2], h[H_W-1:SCALE_LOG2]) : '0;

  // Timing flags delayed one clock to line up with the synchronous RAM read.
  logic vis_d;
  logic hs_d;
  logic vs_d;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  logic [RGB_W-1:0] bar_d;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vis_d <= 1'b0;
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      bar_d <= '0;
`endif
    end else begin
      vis_d <= visible_c;
      hs_d  <= hs_n_c;
      vs_d  <= vs_n_c;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      bar_d <= h[H_W-1:H_W-RGB_W];
`endif
    end
  end

  // Blanked pixels never look at rd_data, so unknown RAM contents stay off the pins.
  rgb_t pixel;
  always_comb begin
    pixel = '0;
    if (vis_d) begin
      pixel = rgb_t'(rd_data);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      if (pattern_sel) begin
        pixel = rgb_t'(bar_d);
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      VGA_BLANK <= 1'b0;
    end else if (pix_en) begin
      VGA_R     <= {DAC_W{pixel.r}};
      VGA_G     <= {DAC_W{pixel.g}};
      VGA_B     <= {DAC_W{pixel.b}};
      VGA_HS    <= hs_d;
      VGA_VS    <= vs_d;
      VGA_BLANK <= vis_d;
    end
  end

  assign VGA_SYNC = 1'b1;
  assign VGA_CLK  = pix_en;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: full-timing instance plus a short-frame instance for vertical checks.
module tb_vga_scanout;
  import vga_scanout_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #10 clock = ~clock;

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  logic pattern_sel = 1'b0;
`endif

  logic [ADDR_W-1:0] rd_addr;
  logic [RGB_W-1:0]  rd_data;
  logic              frame_start;
  logic [DAC_W-1:0]  vga_r, vga_g, vga_b;
  logic              vga_hs, vga_vs, vga_blank, vga_sync, vga_clk;

  vga_scanout dut (
    .clock      (clock),
    .reset      (reset),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_start(frame_start),
    .VGA_R      (vga_r),
    .VGA_G      (vga_g),
    .VGA_B      (vga_b),
    .VGA_HS     (vga_hs),
    .VGA_VS     (vga_vs),
    .VGA_BLANK  (vga_blank),
    .VGA_SYNC   (vga_sync),
    .VGA_CLK    (vga_clk)
  );

  // Short frame: 8 visible + 2 fp + 2 sync + 3 bp = 15 lines -> 24000 clocks per frame.
  logic [ADDR_W-1:0] s_rd_addr;
  logic              s_frame_start;
  logic [DAC_W-1:0]  s_r, s_g, s_b;
  logic              s_hs, s_vs, s_blank, s_sync, s_clk;

  vga_scanout #(.V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_short (
    .clock      (clock),
    .reset      (reset),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    .pattern_sel(1'b0),
`endif
    .rd_addr    (s_rd_addr),
    .rd_data    (3'b000),
    .frame_start(s_frame_start),
    .VGA_R      (s_r),
    .VGA_G      (s_g),
    .VGA_B      (s_b),
    .VGA_HS     (s_hs),
    .VGA_VS     (s_vs),
    .VGA_BLANK  (s_blank),
    .VGA_SYNC   (s_sync),
    .VGA_CLK    (s_clk)
  );

  // RAM model: white at address 0 (what every blanked pixel reads), else low address bits.
  always @(posedge clock) rd_data <= (rd_addr == '0) ? 3'b111 : rd_addr[2:0];

  int unsigned cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Edge monitors sampled on the falling clock edge.
  logic        hs_q, vs_q;
  int unsigned hs_fall [2];
  int unsigned hs_nf, hs_rise0, hs_nr;
  int unsigned vs_fall0, vs_rise0, vs_nf, vs_nr;
  int unsigned fs_cyc [2];
  int unsigned fs_n, fs_full_n;

  always @(negedge clock) begin
    if (reset) begin
      hs_q <= 1'b1; vs_q <= 1'b1;
      hs_nf <= 0; hs_nr <= 0; vs_nf <= 0; vs_nr <= 0; fs_n <= 0; fs_full_n <= 0;
    end else begin
      hs_q <= vga_hs;
      vs_q <= s_vs;
      if (hs_q && !vga_hs && hs_nf < 2) begin hs_fall[hs_nf] <= cyc; hs_nf <= hs_nf + 1; end
      if (!hs_q && vga_hs && hs_nr == 0) begin hs_rise0 <= cyc; hs_nr <= 1; end
      if (vs_q && !s_vs && vs_nf == 0) begin vs_fall0 <= cyc; vs_nf <= 1; end
      if (!vs_q && s_vs && vs_nr == 0) begin vs_rise0 <= cyc; vs_nr <= 1; end
      if (s_frame_start) begin
        if (fs_n < 2) fs_cyc[fs_n] <= cyc;
        fs_n <= fs_n + 1;
      end
      if (frame_start) fs_full_n <= fs_full_n + 1;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clock);
    if (cyc != n) begin
      total++;
      $display("FAIL wait_cyc: overshot to %0d expected %0d", cyc, n);
    end
  endtask

  typedef struct {
    int unsigned h;
    int unsigned v;
    logic [14:0] addr;
    logic        blank;
    logic        hs;
    logic [2:0]  rgb;
  } vec_t;

  vec_t vecs [14];

  task automatic check_rgb(input string tag, input logic [2:0] rgb);
    check({tag, "_r"}, 32'(vga_r), rgb[2] ? 32'h3ff : 32'h0);
    check({tag, "_g"}, 32'(vga_g), rgb[1] ? 32'h3ff : 32'h0);
    check({tag, "_b"}, 32'(vga_b), rgb[0] ? 32'h3ff : 32'h0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0,   0,  15'd0,   1'b1, 1'b1, 3'b111};
    vecs[1]  = '{20,  0,  15'd5,   1'b1, 1'b1, 3'b101};
    vecs[2]  = '{8,   4,  15'd162, 1'b1, 1'b1, 3'b010};
    vecs[3]  = '{4,   8,  15'd321, 1'b1, 1'b1, 3'b001};
    vecs[4]  = '{639, 8,  15'd479, 1'b1, 1'b1, 3'b111};
    vecs[5]  = '{640, 8,  15'd0,   1'b0, 1'b1, 3'b000};
    vecs[6]  = '{655, 8,  15'd0,   1'b0, 1'b1, 3'b000};
    vecs[7]  = '{656, 8,  15'd0,   1'b0, 1'b0, 3'b000};
    vecs[8]  = '{751, 8,  15'd0,   1'b0, 1'b0, 3'b000};
    vecs[9]  = '{752, 8,  15'd0,   1'b0, 1'b1, 3'b000};
    vecs[10] = '{799, 8,  15'd0,   1'b0, 1'b1, 3'b000};
    vecs[11] = '{0,   9,  15'd320, 1'b1, 1'b1, 3'b000};
    vecs[12] = '{13,  9,  15'd323, 1'b1, 1'b1, 3'b011};
    vecs[13] = '{28,  12, 15'd487, 1'b1, 1'b1, 3'b111};

    // Run into line 0, then reset asynchronously mid-line.
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    wait_cyc(301);
    check("pre_reset_blank", 32'(vga_blank), 32'd1);
    check("pre_reset_clk", 32'(vga_clk), 32'd1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_hs", 32'(vga_hs), 32'd1);
    check("rst_vs", 32'(vga_vs), 32'd1);
    check("rst_blank", 32'(vga_blank), 32'd0);
    check("rst_r", 32'(vga_r), 32'd0);
    check("rst_g", 32'(vga_g), 32'd0);
    check("rst_b", 32'(vga_b), 32'd0);
    check("rst_clk", 32'(vga_clk), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("sync_const", 32'(vga_sync), 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("release_addr", 32'(rd_addr), 32'd0);

    // Counters reach pixel p after clock 2p; address seen then, outputs at clock 2p+2.
    for (int i = 0; i < 14; i++) begin
      int unsigned p;
      p = vecs[i].v * 800 + vecs[i].h;
      wait_cyc(2 * p + 1);
      check($sformatf("addr_h%0d_v%0d", vecs[i].h, vecs[i].v), 32'(rd_addr), 32'(vecs[i].addr));
      check($sformatf("clk_h%0d_v%0d", vecs[i].h, vecs[i].v), 32'(vga_clk), 32'd1);
      wait_cyc(2 * p + 2);
      check($sformatf("blank_h%0d_v%0d", vecs[i].h, vecs[i].v), 32'(vga_blank), 32'(vecs[i].blank));
      check($sformatf("hs_h%0d_v%0d", vecs[i].h, vecs[i].v), 32'(vga_hs), 32'(vecs[i].hs));
      check($sformatf("vs_h%0d_v%0d", vecs[i].h, vecs[i].v), 32'(vga_vs), 32'd1);
      check_rgb($sformatf("rgb_h%0d_v%0d", vecs[i].h, vecs[i].v), vecs[i].rgb);
    end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    // h=200 falls in bar 1 (blue) even though RAM would show green at address 530.
    wait_cyc(21000);
    pattern_sel = 1'b1;
    wait_cyc(2 * (13 * 800 + 200) + 2);
    check("pat_blank", 32'(vga_blank), 32'd1);
    check_rgb("pat_h200", 3'b001);
    wait_cyc(2 * (13 * 800 + 700) + 2);
    check_rgb("pat_blanked", 3'b000);
    pattern_sel = 1'b0;
`endif

    wait_cyc(48005);
    check("hs_fall0", hs_fall[0], 32'd1314);
    check("hs_rise0", hs_rise0, 32'd1506);
    check("hs_fall1", hs_fall[1], 32'd2914);
    check("vs_fall", vs_fall0, 32'd16002);
    check("vs_rise", vs_rise0, 32'd19202);
    check("fs_first", fs_cyc[0], 32'd24000);
    check("fs_second", fs_cyc[1], 32'd48000);
    check("fs_count", fs_n, 32'd2);
    check("fs_full_none", fs_full_n, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
